fork_join_ctrl: RTL and testbench

Clocked scheduler that forks one job to `NUM_BR` parallel worker branches and joins their completions, either on the first finisher (join_any) or on all finishers (join_all). It is the hardware counterpart of the fork/join_any behaviour the team exercises in simulation. It sits between a job source and a bank of identical pipeline workers, and it cancels losing branches after a join_any.

---
 rtl/fj_pkg.sv | 24 ++
 rtl/fj_prio_enc.sv | 29 ++
 rtl/fork_join_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_fork_join_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fj_pkg.sv
// Shared types and constants for the fork/join controller.
//
// Contents:
//   fj_state_t : controller states IDLE, FORK, WAIT, KILL, DONE
//   fj_mode_t  : join policy, FJ_ANY (first finisher) or FJ_ALL (every finisher)
//   FJ_MAX_BR  : largest supported branch count
package fj_pkg;

    localparam int unsigned FJ_MAX_BR = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FORK = 3'd1,
        WAIT = 3'd2,
        KILL = 3'd3,
        DONE = 3'd4
    } fj_state_t;

    typedef enum logic {
        FJ_ANY = 1'b0,
        FJ_ALL = 1'b1
    } fj_mode_t;

endpackage

// File: rtl/fj_prio_enc.sv
// Lowest-index priority encoder.
//
// Ports:
//   mask_i : Width-bit request mask
//   idx_o  : index of the lowest set bit (0 when mask_i is empty)
//   any_o  : 1 when at least one bit of mask_i is set
module fj_prio_enc
    import fj_pkg::*;
#(
    parameter int unsigned Width = 3,
    parameter int unsigned IdxW  = 2
) (
    input  logic [Width-1:0] mask_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = |mask_i;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join scheduler: forks one job to NUM_BR worker branches, joins their
// completions on the first finisher (join_any) or on all finishers (join_all),
// and cancels the losing branches after a join_any.
//
// Optional feature: define FJ_TIMEOUT_EN to bound the time spent in WAIT to
// TIMEOUT_CYC cycles; on expiry the unfinished branches are killed and the record
// carries cmp_timeout=1. Without the macro WAIT is unbounded and cmp_timeout is 0.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/ready/id/mode : job request handshake, tag and join policy
//   br_start              : one-cycle start pulse to every branch
//   br_done               : one-cycle completion pulse per branch
//   br_kill               : one-cycle cancel pulse per losing branch
//   cmp_valid/ready       : completion record handshake
//   cmp_id                : tag of the completed job
//   cmp_winner            : lowest index among the first cycle's finishers
//   cmp_mask              : branches that finished before the join
//   cmp_timeout           : job ended by timeout
//
// All outputs are decoded purely from registered state.
module fork_join_ctrl
    import fj_pkg::*;
#(
    parameter int unsigned NUM_BR      = 3,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned TIMEOUT_CYC = 16,
    localparam int unsigned WinW       = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_id,
    input  logic              req_mode,
    output logic [NUM_BR-1:0] br_start,
    input  logic [NUM_BR-1:0] br_done,
    output logic [NUM_BR-1:0] br_kill,
    output logic              cmp_valid,
    input  logic              cmp_ready,
    output logic [ID_W-1:0]   cmp_id,
    output logic [WinW-1:0]   cmp_winner,
    output logic [NUM_BR-1:0] cmp_mask,
    output logic              cmp_timeout
);

    if (NUM_BR < 2 || NUM_BR > FJ_MAX_BR || TIMEOUT_CYC < 1) begin : g_param_check
        $error("fork_join_ctrl: NUM_BR must be 2..%0d and TIMEOUT_CYC nonzero", FJ_MAX_BR);
    end

    fj_state_t         state_q, state_d;
    fj_mode_t          mode_q, mode_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [NUM_BR-1:0] done_mask_q, done_mask_d;
    logic [NUM_BR-1:0] kill_mask_q, kill_mask_d;
    logic [WinW-1:0]   winner_q, winner_d;

    logic [NUM_BR-1:0] done_acc;
    logic [NUM_BR-1:0] pending;
    logic [WinW-1:0]   first_idx;
    logic              first_any;
    logic              join_ok;
    logic              expired;

    fj_prio_enc #(
        .Width (NUM_BR),
        .IdxW  (WinW)
    ) u_prio_enc (
        .mask_i (br_done),
        .idx_o  (first_idx),
        .any_o  (first_any)
    );

    // Completion set as it would stand after this cycle's pulses.
    assign done_acc = done_mask_q | br_done;
    assign pending  = ~done_acc;

    // join_any ends WAIT on any pulse; join_all only once every branch has reported.
    assign join_ok = (mode_q == FJ_ANY) ? first_any : (&done_acc);

`ifdef FJ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // cnt_q holds the number of WAIT cycles already completed, so the
    // TIMEOUT_CYC-th WAIT cycle is the last one allowed.
    assign expired = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    assign expired = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= FJ_ANY;
            id_q        <= '0;
            done_mask_q <= '0;
            kill_mask_q <= '0;
            winner_q    <= '0;
`ifdef FJ_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            done_mask_q <= done_mask_d;
            kill_mask_q <= kill_mask_d;
            winner_q    <= winner_d;
`ifdef FJ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        id_d        = id_q;
        done_mask_d = done_mask_q;
        kill_mask_d = kill_mask_q;
        winner_d    = winner_q;
`ifdef FJ_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = FORK;
                    id_d        = req_id;
                    mode_d      = fj_mode_t'(req_mode);
                    done_mask_d = '0;
                    kill_mask_d = '0;
                    winner_d    = '0;
`ifdef FJ_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                end
            end

            // br_done is deliberately not sampled while the start pulse is out.
            FORK: begin
                state_d = WAIT;
`ifdef FJ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            WAIT: begin
                done_mask_d = done_acc;
                // An empty mask means this is the first cycle with any finisher.
                if (done_mask_q == '0 && first_any) begin
                    winner_d = first_idx;
                end
`ifdef FJ_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                // A join satisfied in the expiry cycle takes precedence.
                if (join_ok) begin
                    if (|pending) begin
                        state_d     = KILL;
                        kill_mask_d = pending;
                    end else begin
                        state_d = DONE;
                    end
                end else if (expired) begin
                    state_d     = KILL;
                    kill_mask_d = pending;
                    winner_d    = '0;
`ifdef FJ_TIMEOUT_EN
                    timeout_d   = 1'b1;
`endif
                end
            end

            KILL: begin
                state_d = DONE;
            end

            DONE: begin
                if (cmp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        req_ready   = 1'b0;
        br_start    = '0;
        br_kill     = '0;
        cmp_valid   = 1'b0;
        cmp_id      = '0;
        cmp_winner  = '0;
        cmp_mask    = '0;
        cmp_timeout = 1'b0;

        unique case (state_q)
            IDLE: req_ready = 1'b1;
            FORK: br_start  = '1;
            KILL: br_kill   = kill_mask_q;
            DONE: begin
                cmp_valid   = 1'b1;
                cmp_id      = id_q;
                cmp_winner  = winner_q;
                cmp_mask    = done_mask_q;
`ifdef FJ_TIMEOUT_EN
                cmp_timeout = timeout_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Self-checking bench for fork_join_ctrl: directed scenarios with literal
// expectations plus randomized jobs checked cycle by cycle against a
// transaction-level model of the join rules.
module tb_fork_join_ctrl;

    localparam int unsigned NB   = 3;
    localparam int unsigned IDW  = 4;
    localparam int unsigned TCYC = 16;
    localparam int unsigned WW   = $clog2(NB);
    localparam int          MAXK = 40;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [IDW-1:0] req_id;
    logic           req_mode;
    logic [NB-1:0]  br_start;
    logic [NB-1:0]  br_done;
    logic [NB-1:0]  br_kill;
    logic           cmp_valid;
    logic           cmp_ready;
    logic [IDW-1:0] cmp_id;
    logic [WW-1:0]  cmp_winner;
    logic [NB-1:0]  cmp_mask;
    logic           cmp_timeout;

    always #5 clk = ~clk;

    fork_join_ctrl #(
        .NUM_BR      (NB),
        .ID_W        (IDW),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_id      (req_id),
        .req_mode    (req_mode),
        .br_start    (br_start),
        .br_done     (br_done),
        .br_kill     (br_kill),
        .cmp_valid   (cmp_valid),
        .cmp_ready   (cmp_ready),
        .cmp_id      (cmp_id),
        .cmp_winner  (cmp_winner),
        .cmp_mask    (cmp_mask),
        .cmp_timeout (cmp_timeout)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    // Expected outputs for the current cycle.
    logic           exp_req_ready;
    logic [NB-1:0]  exp_br_start;
    logic [NB-1:0]  exp_br_kill;
    logic           exp_cmp_valid;
    logic [IDW-1:0] exp_cmp_id;
    logic [WW-1:0]  exp_cmp_winner;
    logic [NB-1:0]  exp_cmp_mask;
    logic           exp_cmp_timeout;

    // Done pulses per WAIT cycle (index 1 = first WAIT cycle).
    logic [NB-1:0] pulse [1:MAXK];

    // Model results for the job being run.
    int            m_w;
    logic [WW-1:0] m_win;
    logic [NB-1:0] m_mask;
    logic [NB-1:0] m_kill;
    logic          m_tmo;

    // Observations for directed literal checks.
    logic [NB-1:0]  obs_start;
    logic [NB-1:0]  obs_kill;
    logic [IDW-1:0] obs_id;
    logic [WW-1:0]  obs_win;
    logic [NB-1:0]  obs_mask;
    logic           obs_tmo;
    int             obs_lat;
    int             obs_vcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_req_ready));
            check("br_start", 32'(br_start), 32'(exp_br_start));
            check("br_kill", 32'(br_kill), 32'(exp_br_kill));
            check("cmp_valid", 32'(cmp_valid), 32'(exp_cmp_valid));
            if (exp_cmp_valid) begin
                check("cmp_id", 32'(cmp_id), 32'(exp_cmp_id));
                check("cmp_winner", 32'(cmp_winner), 32'(exp_cmp_winner));
                check("cmp_mask", 32'(cmp_mask), 32'(exp_cmp_mask));
                check("cmp_timeout", 32'(cmp_timeout), 32'(exp_cmp_timeout));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic exp_idle();
        exp_req_ready = 1'b1;
        exp_br_start  = '0;
        exp_br_kill   = '0;
        exp_cmp_valid = 1'b0;
    endtask

    task automatic exp_busy(input logic [NB-1:0] st, input logic [NB-1:0] kl);
        exp_req_ready = 1'b0;
        exp_br_start  = st;
        exp_br_kill   = kl;
        exp_cmp_valid = 1'b0;
    endtask

    function automatic logic [WW-1:0] lowest(input logic [NB-1:0] v);
        bit found;
        lowest = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            if (!found && v[i]) begin
                lowest = WW'(i);
                found  = 1'b1;
            end
        end
    endfunction

    // Walk the WAIT cycles applying the join rules to the pulse schedule.
    task automatic model(input logic mode);
        logic [NB-1:0] acc;
        bit            seen;
        acc   = '0;
        seen  = 1'b0;
        m_w   = 0;
        m_win = '0;
        m_tmo = 1'b0;
        for (int k = 1; k <= MAXK; k++) begin
`ifdef FJ_TIMEOUT_EN
            if (k > int'(TCYC)) begin
                m_tmo = 1'b1;
                m_w   = int'(TCYC);
                m_win = '0;
                break;
            end
`endif
            acc = acc | pulse[k];
            if (!seen && pulse[k] != '0) begin
                seen  = 1'b1;
                m_win = lowest(pulse[k]);
            end
            if (mode ? (acc == '1) : (pulse[k] != '0)) begin
                m_w = k;
                break;
            end
        end
        m_mask = acc;
        m_kill = (mode && !m_tmo) ? '0 : ~acc;
    endtask

    task automatic clear_pulses();
        for (int k = 1; k <= MAXK; k++) pulse[k] = '0;
    endtask

    function automatic logic [NB-1:0] late_done(input int k);
        late_done = (k <= MAXK) ? pulse[k] : NB'($urandom);
    endfunction

    // Runs one job starting in the current (IDLE) cycle; returns in the IDLE
    // cycle after the completion handshake.
    task automatic run_job(input logic [IDW-1:0] id, input logic mode, input int rdy_dly,
                           input logic [NB-1:0] fork_noise, input bit keep_valid);
        int k;
        model(mode);
        obs_start = '0;
        obs_kill  = '0;
        obs_lat   = -1;
        obs_vcnt  = 0;
        cyc       = 0;
        if (m_w == 0) begin
            checks++;
            errors++;
            $display("FAIL schedule: join never satisfied, got w=0, required w>0");
            return;
        end
        // Accept cycle.
        req_valid = 1'b1;
        req_id    = id;
        req_mode  = mode;
        br_done   = NB'($urandom);
        cmp_ready = 1'($urandom);
        exp_idle();
        step();
        // FORK.
        req_valid = 1'($urandom);
        req_id    = IDW'($urandom);
        req_mode  = 1'($urandom);
        br_done   = fork_noise;
        exp_busy('1, '0);
        obs_start = br_start;
        step();
        // WAIT.
        for (k = 1; k <= m_w; k++) begin
            br_done   = pulse[k];
            req_valid = 1'($urandom);
            cmp_ready = 1'($urandom);
            exp_busy('0, '0);
            step();
        end
        k = m_w + 1;
        // KILL.
        if (m_kill != '0) begin
            br_done = late_done(k);
            k++;
            exp_busy('0, m_kill);
            obs_kill = br_kill;
            step();
        end
        // DONE, with optional backpressure.
        for (int j = 0; j <= rdy_dly; j++) begin
            br_done         = late_done(k);
            k++;
            cmp_ready       = (j == rdy_dly);
            req_valid       = keep_valid ? 1'b1 : 1'($urandom);
            exp_req_ready   = 1'b0;
            exp_br_start    = '0;
            exp_br_kill     = '0;
            exp_cmp_valid   = 1'b1;
            exp_cmp_id      = id;
            exp_cmp_winner  = m_win;
            exp_cmp_mask    = m_mask;
            exp_cmp_timeout = m_tmo;
            if (cmp_valid === 1'b1) begin
                obs_vcnt++;
                if (obs_lat < 0) obs_lat = cyc;
                obs_id   = cmp_id;
                obs_win  = cmp_winner;
                obs_mask = cmp_mask;
                obs_tmo  = cmp_timeout;
            end
            step();
        end
        req_valid = 1'b0;
        cmp_ready = 1'b0;
        br_done   = '0;
        exp_idle();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            br_done   = NB'($urandom);
            cmp_ready = 1'($urandom);
            exp_idle();
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_id    = '0;
        req_mode  = 1'b0;
        br_done   = '0;
        cmp_ready = 1'b0;
        exp_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_br_start", 32'(br_start), 32'd0);
        check("rst_br_kill", 32'(br_kill), 32'd0);
        check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        check("rst_cmp_id", 32'(cmp_id), 32'd0);
        check("rst_cmp_mask", 32'(cmp_mask), 32'd0);
        check("rst_cmp_winner", 32'(cmp_winner), 32'd0);
        check("rst_cmp_timeout", 32'(cmp_timeout), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2);

        // join_any: br1@1, br0@3, br2@10.
        clear_pulses();
        pulse[1]  = 3'b010;
        pulse[3]  = 3'b001;
        pulse[10] = 3'b100;
        run_job(4'd5, 1'b0, 0, '0, 1'b0);
        check("any_kill", 32'(obs_kill), 32'b101);
        check("any_id", 32'(obs_id), 32'd5);
        check("any_winner", 32'(obs_win), 32'd1);
        check("any_mask", 32'(obs_mask), 32'b010);
        check("any_timeout", 32'(obs_tmo), 32'd0);
        check("any_latency", 32'(obs_lat), 32'd4);

        // join_all: br0@2, br1@4, br2@6.
        idle_cycles(1);
        clear_pulses();
        pulse[2] = 3'b001;
        pulse[4] = 3'b010;
        pulse[6] = 3'b100;
        run_job(4'd9, 1'b1, 0, '0, 1'b0);
        check("all_kill", 32'(obs_kill), 32'd0);
        check("all_id", 32'(obs_id), 32'd9);
        check("all_mask", 32'(obs_mask), 32'b111);
        check("all_winner", 32'(obs_win), 32'd0);
        check("all_latency", 32'(obs_lat), 32'd8);

        // Simultaneous join_any finish of br2 and br0, late br1 ignored.
        clear_pulses();
        pulse[2] = 3'b101;
        pulse[3] = 3'b010;
        pulse[4] = 3'b010;
        run_job(4'd3, 1'b0, 1, 3'b111, 1'b0);
        check("sim_winner", 32'(obs_win), 32'd0);
        check("sim_mask", 32'(obs_mask), 32'b101);
        check("sim_kill", 32'(obs_kill), 32'b010);
        check("sim_latency", 32'(obs_lat), 32'd5);

        // Backpressure: 5 stalled cycles with req_valid held, then an
        // immediate next job whose start pulse lands 2 cycles after handshake.
        clear_pulses();
        pulse[1] = 3'b111;
        run_job(4'd12, 1'b0, 5, '0, 1'b1);
        check("bp_valid_cycles", 32'(obs_vcnt), 32'd6);
        check("bp_mask", 32'(obs_mask), 32'b111);
        check("bp_kill", 32'(obs_kill), 32'd0);
        clear_pulses();
        pulse[2] = 3'b100;
        run_job(4'd1, 1'b0, 0, '0, 1'b0);
        check("bp_next_start", 32'(obs_start), 32'b111);
        check("bp_next_winner", 32'(obs_win), 32'd2);

        // Reset in WAIT, then late done pulses must produce nothing.
        req_valid = 1'b1;
        req_id    = 4'd7;
        req_mode  = 1'b1;
        br_done   = '0;
        exp_idle();
        step();
        req_valid = 1'b0;
        exp_busy('1, '0);
        step();
        br_done = 3'b000;
        exp_busy('0, '0);
        step();
        reset   = 1'b1;
        br_done = 3'b001;
        exp_busy('0, '0);
        step();
        reset   = 1'b0;
        br_done = 3'b110;
        exp_idle();
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        check("rstw_br_kill", 32'(br_kill), 32'd0);
        check("rstw_cmp_valid", 32'(cmp_valid), 32'd0);
        check("rstw_cmp_mask", 32'(cmp_mask), 32'd0);
        check("rstw_cmp_id", 32'(cmp_id), 32'd0);
        step();
        idle_cycles(5);

`ifdef FJ_TIMEOUT_EN
        // join_all with br1 never finishing.
        clear_pulses();
        pulse[3] = 3'b001;
        pulse[5] = 3'b100;
        run_job(4'd6, 1'b1, 0, '0, 1'b0);
        check("tmo_kill", 32'(obs_kill), 32'b010);
        check("tmo_timeout", 32'(obs_tmo), 32'd1);
        check("tmo_mask", 32'(obs_mask), 32'b101);
        check("tmo_winner", 32'(obs_win), 32'd0);
        check("tmo_latency", 32'(obs_lat), 32'd19);
`endif

        // Randomized jobs.
        for (int n = 0; n < 150; n++) begin
            clear_pulses();
            for (int b = 0; b < int'(NB); b++) begin
                int  span;
                int  t;
                bit  never;
                span  = ($urandom_range(0, 1) == 1) ? 6 : 20;
                never = 1'b0;
`ifdef FJ_TIMEOUT_EN
                never = ($urandom_range(0, 4) == 0);
`endif
                if (!never) begin
                    t = int'($urandom_range(1, span));
                    pulse[t][b] = 1'b1;
                end
                if ($urandom_range(0, 2) == 0) begin
                    t = int'($urandom_range(1, MAXK));
                    pulse[t][b] = 1'b1;
                end
            end
            run_job(IDW'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    NB'($urandom), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
